// File: rtl/fpu_normalizer.sv
// Multi-cycle post-add normalizer: absorbs the adder carry with a 1-bit right shift, or removes
// leading zeros with an exponent-limited log shifter. Optional sticky tracking: FPU_NORM_STICKY_EN.
module fpu_normalizer #(
    parameter int MW = 46,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          carry_in,
    input  logic [MW-1:0] mant_in,
    input  logic [EW-1:0] exp_in,
    input  logic          sticky_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] mant_out,
    output logic [EW-1:0] exp_out,
    output logic          zero,
    output logic          underflow,
    output logic          overflow,
    output logic          sticky_out
);

    localparam int S  = $clog2(MW);
    localparam int SW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        r_state, w_state_next;
    logic [MW-1:0] r_mant, w_mant_next;
    logic [EW-1:0] r_exp, w_exp_next;
    logic [SW-1:0] r_stage, w_stage_next;
    logic          r_zero, w_zero_next;
    logic          r_underflow, w_underflow_next;
    logic          r_overflow, w_overflow_next;
    logic          r_sticky, w_sticky_next;

    logic          w_sticky_carry;
    logic          w_sticky_plain;

`ifdef FPU_NORM_STICKY_EN
    assign w_sticky_carry = sticky_in | mant_in[0];
    assign w_sticky_plain = sticky_in;
`else
    logic w_unused_sticky;
    assign w_unused_sticky = sticky_in;
    assign w_sticky_carry  = 1'b0;
    assign w_sticky_plain  = 1'b0;
`endif

    // One candidate per shift stage; r_exp doubles as the remaining shift budget because both
    // start at exp_in and are decremented together.
    logic [MW-1:0] w_stage_mant [S];
    logic [EW-1:0] w_stage_exp  [S];
    logic          w_stage_take [S];

    generate
        for (genvar gi = 0; gi < S; gi++) begin : g_stage
            if ((1 << gi) <= MW) begin : g_live
                localparam int          STEP   = 1 << gi;
                localparam logic [31:0] STEP32 = 32'(STEP);
                assign w_stage_take[gi] = (r_mant[MW-1 -: STEP] == '0) && (32'(r_exp) >= STEP32);
                assign w_stage_mant[gi] = r_mant << STEP;
                assign w_stage_exp[gi]  = r_exp - EW'(STEP32);
            end else begin : g_dead
                assign w_stage_take[gi] = 1'b0;
                assign w_stage_mant[gi] = r_mant;
                assign w_stage_exp[gi]  = r_exp;
            end
        end
    endgenerate

    logic [MW-1:0] w_shift_mant;
    logic [EW-1:0] w_shift_exp;

    assign w_shift_mant = w_stage_take[r_stage] ? w_stage_mant[r_stage] : r_mant;
    assign w_shift_exp  = w_stage_take[r_stage] ? w_stage_exp[r_stage]  : r_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mant      <= '0;
            r_exp       <= '0;
            r_stage     <= '0;
            r_zero      <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_mant      <= w_mant_next;
            r_exp       <= w_exp_next;
            r_stage     <= w_stage_next;
            r_zero      <= w_zero_next;
            r_underflow <= w_underflow_next;
            r_overflow  <= w_overflow_next;
            r_sticky    <= w_sticky_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_mant_next      = r_mant;
        w_exp_next       = r_exp;
        w_stage_next     = r_stage;
        w_zero_next      = r_zero;
        w_underflow_next = r_underflow;
        w_overflow_next  = r_overflow;
        w_sticky_next    = r_sticky;

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_zero_next      = 1'b0;
                    w_underflow_next = 1'b0;
                    w_overflow_next  = 1'b0;
                    if (carry_in) begin
                        w_sticky_next = w_sticky_carry;
                        w_state_next  = DONE;
                        if (&exp_in) begin
                            w_mant_next     = '0;
                            w_exp_next      = '1;
                            w_overflow_next = 1'b1;
                        end else begin
                            w_mant_next = {1'b1, mant_in[MW-1:1]};
                            w_exp_next  = exp_in + 1'b1;
                        end
                    end else if (mant_in == '0) begin
                        w_mant_next   = '0;
                        w_exp_next    = '0;
                        w_zero_next   = 1'b1;
                        w_sticky_next = w_sticky_plain;
                        w_state_next  = DONE;
                    end else begin
                        w_mant_next   = mant_in;
                        w_exp_next    = exp_in;
                        w_stage_next  = SW'(S - 1);
                        w_sticky_next = w_sticky_plain;
                        w_state_next  = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_mant_next = w_shift_mant;
                w_exp_next  = w_shift_exp;
                if (r_stage == '0) begin
                    w_underflow_next = (w_shift_exp == '0) && (w_shift_mant != '0)
                                       && !w_shift_mant[MW-1];
                    w_state_next     = DONE;
                end else begin
                    w_stage_next = r_stage - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_zero_next      = 1'b0;
                    w_underflow_next = 1'b0;
                    w_overflow_next  = 1'b0;
                    w_sticky_next    = 1'b0;
                    w_state_next     = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign mant_out   = r_mant;
    assign exp_out    = r_exp;
    assign zero       = r_zero;
    assign underflow  = r_underflow;
    assign overflow   = r_overflow;
    assign sticky_out = r_sticky;

endmodule

// File: tb/tb_fpu_normalizer.sv
// Self-checking bench for fpu_normalizer: directed vector table, handshake/reset sequences,
// and randomized operands checked against an arithmetic reference model.
module tb_fpu_normalizer;

    localparam int MW = 46;
    localparam int EW = 8;

`ifdef FPU_NORM_STICKY_EN
    localparam bit STK_EN = 1'b1;
`else
    localparam bit STK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          carry_in;
    logic [MW-1:0] mant_in;
    logic [EW-1:0] exp_in;
    logic          sticky_in;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic          zero;
    logic          underflow;
    logic          overflow;
    logic          sticky_out;

    fpu_normalizer #(.MW(MW), .EW(EW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .carry_in   (carry_in),
        .mant_in    (mant_in),
        .exp_in     (exp_in),
        .sticky_in  (sticky_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_out   (mant_out),
        .exp_out    (exp_out),
        .zero       (zero),
        .underflow  (underflow),
        .overflow   (overflow),
        .sticky_out (sticky_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          c;
        logic [MW-1:0] m;
        logic [EW-1:0] e;
        logic          s;
        logic [MW-1:0] xm;
        logic [EW-1:0] xe;
        logic          xz;
        logic          xu;
        logic          xo;
        logic          xs;
        int            lat;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: carry is a 1-bit right shift of {carry,mant}; otherwise shift left by
    // min(leading zeros, exponent). Latency counts edges from the accept edge inclusive.
    function automatic vec_t model(input logic c, input logic [MW-1:0] m,
                                   input logic [EW-1:0] e, input logic s);
        vec_t r;
        logic [MW:0] full;
        int lz, n;
        r.c = c; r.m = m; r.e = e; r.s = s;
        r.xz = 0; r.xu = 0; r.xo = 0; r.xs = 0;
        if (c) begin
            r.lat = 1;
            r.xs  = s | m[0];
            if (int'(e) == (1 << EW) - 1) begin
                r.xm = '0;
                r.xe = e;
                r.xo = 1;
            end else begin
                full = {1'b1, m};
                full = full >> 1;
                r.xm = full[MW-1:0];
                r.xe = EW'(int'(e) + 1);
            end
        end else if (m == 0) begin
            r.lat = 1;
            r.xm  = '0;
            r.xe  = '0;
            r.xz  = 1;
            r.xs  = s;
        end else begin
            r.lat = 7;
            lz = 0;
            for (int i = MW - 1; i >= 0; i--) begin
                if (m[i]) break;
                lz++;
            end
            n    = (lz < int'(e)) ? lz : int'(e);
            r.xm = m << n;
            r.xe = EW'(int'(e) - n);
            r.xu = (r.xe == 0) && !r.xm[MW-1];
            r.xs = s;
        end
        return r;
    endfunction

    task automatic apply(input logic c, input logic [MW-1:0] m, input logic [EW-1:0] e,
                         input logic s, output int lat);
        int guard;
        carry_in = c; mant_in = m; exp_in = e; sticky_in = s; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic compare(input string tag, input vec_t v, input int lat);
        chk({tag, ".lat"},  64'(lat), 64'(v.lat));
        chk({tag, ".vld"},  {63'd0, out_valid}, 64'd1);
        chk({tag, ".mant"}, {18'd0, mant_out}, {18'd0, v.xm});
        chk({tag, ".exp"},  {56'd0, exp_out}, {56'd0, v.xe});
        chk({tag, ".flags"}, {61'd0, zero, underflow, overflow}, {61'd0, v.xz, v.xu, v.xo});
        chk({tag, ".stk"},  {63'd0, sticky_out}, {63'd0, v.xs & STK_EN});
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".retire"}, {60'd0, out_valid, in_ready, zero | underflow | overflow, 1'b0},
            {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    endtask

    vec_t vecs[12];

    initial begin
        int   lat;
        vec_t v;
        logic [MW-1:0] hm;
        logic [EW-1:0] he;
        logic          unstable;
        logic          seen;

        vecs[0]  = '{1'b0, 46'h1,            8'd100,  1'b0, 46'h2000_0000_0000, 8'd55,  0, 0, 0, 0, 7};
        vecs[1]  = '{1'b0, 46'h1,            8'd10,   1'b0, 46'h0000_0000_0400, 8'd0,   0, 1, 0, 0, 7};
        vecs[2]  = '{1'b1, 46'h3FFF_FFFF_FFFF, 8'h7F, 1'b0, 46'h3FFF_FFFF_FFFF, 8'h80,  0, 0, 0, 1, 1};
        vecs[3]  = '{1'b1, 46'h123,          8'hFF,   1'b0, 46'h0,              8'hFF,  0, 0, 1, 1, 1};
        vecs[4]  = '{1'b0, 46'h0,            8'd50,   1'b1, 46'h0,              8'd0,   1, 0, 0, 1, 1};
        vecs[5]  = '{1'b0, 46'h2000_0000_0000, 8'd5,  1'b1, 46'h2000_0000_0000, 8'd5,   0, 0, 0, 1, 7};
        vecs[6]  = '{1'b0, 46'h1,            8'd0,    1'b0, 46'h1,              8'd0,   0, 1, 0, 0, 7};
        vecs[7]  = '{1'b0, 46'h0000_0001_0000, 8'd200, 1'b0, 46'h2000_0000_0000, 8'd171, 0, 0, 0, 0, 7};
        vecs[8]  = '{1'b1, 46'h0,            8'd0,    1'b1, 46'h2000_0000_0000, 8'd1,   0, 0, 0, 1, 1};
        vecs[9]  = '{1'b0, 46'h3,            8'd44,   1'b0, 46'h3000_0000_0000, 8'd0,   0, 0, 0, 0, 7};
        vecs[10] = '{1'b0, 46'h1,            8'd45,   1'b0, 46'h2000_0000_0000, 8'd0,   0, 0, 0, 0, 7};
        vecs[11] = '{1'b0, 46'h1,            8'd44,   1'b0, 46'h1000_0000_0000, 8'd0,   0, 1, 0, 0, 7};

        rst = 1'b1; in_valid = 1'b0; carry_in = 1'b0; mant_in = '0; exp_in = '0;
        sticky_in = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.hs", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        chk("reset.data", {10'd0, mant_out, exp_out}, 64'd0);
        chk("reset.flags", {60'd0, zero, underflow, overflow, sticky_out}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].c, vecs[i].m, vecs[i].e, vecs[i].s, lat);
            compare($sformatf("vec%0d", i), vecs[i], lat);
            $display("vec %0d: c=%0b m=%h e=%0d -> m=%h e=%0d z=%0b u=%0b o=%0b s=%0b lat=%0d",
                     i, vecs[i].c, vecs[i].m, vecs[i].e, mant_out, exp_out, zero, underflow,
                     overflow, sticky_out, lat);
            retire($sformatf("vec%0d", i));
        end

        // Backpressure: outputs frozen while out_ready stays low.
        apply(1'b0, 46'h0000_00F0_0000, 8'd90, 1'b0, lat);
        hm = mant_out; he = exp_out; unstable = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (mant_out !== hm || exp_out !== he || !out_valid || in_ready) unstable = 1'b1;
        end
        chk("hold.stable", {63'd0, unstable}, 64'd0);
        v = model(1'b0, 46'h0000_00F0_0000, 8'd90, 1'b0);
        chk("hold.mant", {18'd0, mant_out}, {18'd0, v.xm});
        $display("hold: m=%h e=%0d stable=%0b", mant_out, exp_out, !unstable);
        retire("hold");
        apply(1'b1, 46'h2, 8'd3, 1'b1, lat);
        compare("b2b", model(1'b1, 46'h2, 8'd3, 1'b1), lat);
        $display("b2b: m=%h e=%0d lat=%0d", mant_out, exp_out, lat);
        retire("b2b");

        // Reset while the shifter is on stage 3 discards the operand.
        carry_in = 1'b0; mant_in = 46'h1; exp_in = 8'd100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.hs", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("rstmid.noout", {63'd0, seen}, 64'd0);
        $display("rstmid: in_ready=%0b ghost_output=%0b", in_ready, seen);

        for (int i = 0; i < 150; i++) begin
            logic          c, s;
            logic [MW-1:0] m;
            logic [EW-1:0] e;
            c = ($urandom_range(0, 7) == 0);
            s = $urandom_range(0, 1) == 1;
            m = MW'({$urandom, $urandom} >> $urandom_range(0, 52));
            e = ($urandom_range(0, 3) == 0) ? EW'($urandom_range(0, 50)) : EW'($urandom);
            v = model(c, m, e, s);
            apply(c, m, e, s, lat);
            compare($sformatf("rnd%0d", i), v, lat);
            $display("rnd %0d: c=%0b m=%h e=%0d -> m=%h e=%0d z=%0b u=%0b o=%0b lat=%0d",
                     i, c, m, e, mant_out, exp_out, zero, underflow, overflow, lat);
            retire($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
